// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32 opcode/funct3 constants, NOP encoding and execute-stage FSM state type
package rv32_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        WAKE = 1'b0,
        RUN  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational RV32 branch condition evaluation
module branch_cmp
    import rv32_pkg::*;
(
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_data == rs2_data);
            F3_BNE:  taken = (rs1_data != rs2_data);
            F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken = (rs1_data <  rs2_data);
            F3_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/iexec_ctrl.sv
// rtl/iexec_ctrl.sv - RV32 execute-stage front end: execute register, jump/branch resolve, retire count
// Optional misaligned-target trap enabled by defining IEXEC_MISALIGN_TRAP_EN.
module iexec_ctrl
    import rv32_pkg::*;
`ifdef IEXEC_MISALIGN_TRAP_EN
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h00000100
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] f_instr_next,
    input  logic [31:0] f_pc_next,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        busy,
    output logic        e_valid,
    output logic        e_clk_en,
    output logic        jump_select,
    output logic [31:0] e_pc_next,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        x_valid,
    output logic [31:0] x_instr,
    output logic [31:0] x_pc,
    output logic [31:0] x_link,
    output logic        x_trap,
    output logic [31:0] x_retire_cnt
);

    exec_state_t state;

    logic        retire;
    logic        taken;
    logic        br_taken;
    logic [31:0] imm_i;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAKE;
            e_valid <= 1'b0;
        end else begin
            case (state)
                WAKE: begin
                    state   <= RUN;
                    e_valid <= 1'b1;
                end
                RUN: begin
                    state   <= RUN;
                    e_valid <= 1'b1;
                end
                default: begin
                    state   <= WAKE;
                    e_valid <= 1'b0;
                end
            endcase
        end
    end

    assign retire      = x_valid && !busy;
    assign e_clk_en    = !(x_valid && busy);
    assign jump_select = retire && taken;

    // The wrong-path instruction fetch is presenting during a redirect enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid <= 1'b0;
            x_instr <= NOP_INSTR;
            x_pc    <= 32'h0;
        end else if (e_clk_en) begin
            x_valid <= i_valid && !jump_select;
            x_instr <= f_instr_next;
            x_pc    <= f_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_retire_cnt <= 32'h0;
        end else if (retire) begin
            x_retire_cnt <= x_retire_cnt + 32'd1;
        end
    end

    assign rs1_addr = x_instr[19:15];
    assign rs2_addr = x_instr[24:20];
    assign x_link   = x_pc + 32'd4;

    assign imm_i = {{20{x_instr[31]}}, x_instr[31:20]};
    assign imm_j = {{12{x_instr[31]}}, x_instr[19:12], x_instr[20], x_instr[30:21], 1'b0};
    assign imm_b = {{20{x_instr[31]}}, x_instr[7], x_instr[30:25], x_instr[11:8], 1'b0};

    branch_cmp u_branch_cmp (
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .funct3   (x_instr[14:12]),
        .taken    (br_taken)
    );

    always_comb begin
        taken  = 1'b0;
        target = x_link;
        case (x_instr[6:0])
            OP_JAL: begin
                taken  = 1'b1;
                target = x_pc + imm_j;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = (rs1_data + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                taken  = br_taken;
                target = x_pc + imm_b;
            end
            default: begin
                taken  = 1'b0;
                target = x_link;
            end
        endcase
    end

`ifdef IEXEC_MISALIGN_TRAP_EN
    assign e_pc_next = (taken && target[1]) ? TRAP_VECTOR : target;
    assign x_trap    = jump_select && target[1];
`else
    assign e_pc_next = target;
    assign x_trap    = 1'b0;
`endif

endmodule

// File: tb/tb_iexec_ctrl.sv
// tb/tb_iexec_ctrl.sv - self-checking bench for iexec_ctrl (directed plan plus randomized traffic vs. reference model)
module tb_iexec_ctrl;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] JAL  = 32'h010000EF;
    localparam logic [31:0] BEQ  = 32'hFE208CE3;
    localparam logic [31:0] JALR = 32'h004280E7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] f_instr_next;
    logic [31:0] f_pc_next;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        e_valid;
    logic        e_clk_en;
    logic        jump_select;
    logic [31:0] e_pc_next;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        x_valid;
    logic [31:0] x_instr;
    logic [31:0] x_pc;
    logic [31:0] x_link;
    logic        x_trap;
    logic [31:0] x_retire_cnt;

    logic [31:0] rf [32];

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic        m_run;
    logic        m_v;
    logic [31:0] m_ins;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    iexec_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .f_instr_next (f_instr_next),
        .f_pc_next    (f_pc_next),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .busy         (busy),
        .e_valid      (e_valid),
        .e_clk_en     (e_clk_en),
        .jump_select  (jump_select),
        .e_pc_next    (e_pc_next),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .x_valid      (x_valid),
        .x_instr      (x_instr),
        .x_pc         (x_pc),
        .x_link       (x_link),
        .x_trap       (x_trap),
        .x_retire_cnt (x_retire_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ISA-level outcome of one instruction: does it redirect, and where to.
    function automatic void predict(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic tk, output logic [31:0] tgt);
        int signed   sa, sb;
        logic [31:0] off;
        sa  = a;
        sb  = b;
        tk  = 1'b0;
        tgt = pc + 32'd4;
        if (ins[6:0] == 7'h6F) begin
            off = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            tk  = 1'b1;
            tgt = pc + off;
        end else if (ins[6:0] == 7'h67) begin
            off = {{20{ins[31]}}, ins[31:20]};
            tk  = 1'b1;
            tgt = (a + off) & 32'hFFFF_FFFE;
        end else if (ins[6:0] == 7'h63) begin
            off = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            tgt = pc + off;
            case (ins[14:12])
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = (sa < sb);
                3'd5: tk = (sa >= sb);
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: tk = 1'b0;
            endcase
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic        tk;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_run = 1'b0;
            m_v   = 1'b0;
            m_ins = NOP;
            m_pc  = 32'h0;
            m_cnt = 32'h0;
        end else begin
            predict(m_ins, m_pc, rf[m_ins[19:15]], rf[m_ins[24:20]], tk, tgt);
            m_run = 1'b1;
            if (m_v && busy) begin
                // stalled: nothing moves
            end else begin
                if (m_v) m_cnt = m_cnt + 1;
                m_v   = i_valid && !(m_v && tk);
                m_ins = f_instr_next;
                m_pc  = f_pc_next;
            end
        end
    end

    always @(negedge clk) begin
        logic        tk, js, trap;
        logic [31:0] tgt, npc;
        predict(m_ins, m_pc, rf[m_ins[19:15]], rf[m_ins[24:20]], tk, tgt);
        js   = m_v && !busy && tk;
        npc  = tgt;
        trap = 1'b0;
`ifdef IEXEC_MISALIGN_TRAP_EN
        if (tk && tgt[1]) npc = 32'h00000100;
        trap = js && tgt[1];
`endif
        chk("m_e_valid", e_valid, m_run);
        chk("m_x_valid", x_valid, m_v);
        chk("m_x_instr", x_instr, m_ins);
        chk("m_x_pc", x_pc, m_pc);
        chk("m_x_link", x_link, m_pc + 32'd4);
        chk("m_rs_addr", {rs1_addr, rs2_addr}, {m_ins[19:15], m_ins[24:20]});
        chk("m_retire_cnt", x_retire_cnt, m_cnt);
        chk("m_e_clk_en", e_clk_en, !(m_v && busy));
        chk("m_jump_select", jump_select, js);
        chk("m_e_pc_next", e_pc_next, npc);
        chk("m_x_trap", x_trap, trap);
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic b);
        i_valid      = v;
        f_instr_next = ins;
        f_pc_next    = pc;
        busy         = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_e_valid"}, e_valid, 0);
        chk({tag, "_x_valid"}, x_valid, 0);
        chk({tag, "_x_instr"}, x_instr, 32'h13);
        chk({tag, "_x_pc"}, x_pc, 0);
        chk({tag, "_cnt"}, x_retire_cnt, 0);
        chk({tag, "_e_clk_en"}, e_clk_en, 1);
        chk({tag, "_jump_select"}, jump_select, 0);
        chk({tag, "_x_trap"}, x_trap, 0);
        chk({tag, "_e_pc_next"}, e_pc_next, 32'h4);
        chk({tag, "_x_link"}, x_link, 32'h4);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0: w[6:0] = 7'h6F;
            1: w[6:0] = 7'h67;
            2, 3: w[6:0] = 7'h63;
            default: w[6:0] = 7'h13;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] base;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0;
        drive(0, NOP, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        // NOP stream after reset release
        rst_n = 1'b1;
        drive(1, NOP, 32'h0, 0);
        #1;
        chk("wake_e_valid", e_valid, 0);
        tick();
        chk("run_e_valid", e_valid, 1);
        chk("nop0_x_pc", x_pc, 32'h0);
        chk("nop0_x_valid", x_valid, 1);
        drive(1, NOP, 32'h4, 0);
        tick();
        chk("nop1_x_pc", x_pc, 32'h4);
        drive(1, NOP, 32'h8, 0);
        tick();
        chk("nop2_x_pc", x_pc, 32'h8);
        drive(1, NOP, 32'hC, 0);
        tick();
        chk("nop_cnt3", x_retire_cnt, 3);

        // JAL x1, +0x10 at 0x8
        drive(1, JAL, 32'h8, 0);
        tick();
        drive(1, NOP, 32'hC, 0);
        #1;
        chk("jal_js", jump_select, 1);
        chk("jal_target", e_pc_next, 32'h18);
        chk("jal_link", x_link, 32'hC);
        tick();
        chk("jal_bubble", x_valid, 0);

        // BEQ x1, x2, -8 at 0x20
        rf[1] = 32'd1;
        rf[2] = 32'd1;
        drive(1, BEQ, 32'h20, 0);
        tick();
        drive(1, NOP, 32'h24, 0);
        #1;
        chk("beq_t_js", jump_select, 1);
        chk("beq_t_target", e_pc_next, 32'h18);
        tick();
        chk("beq_t_bubble", x_valid, 0);
        rf[2] = 32'd2;
        drive(1, BEQ, 32'h20, 0);
        tick();
        drive(1, NOP, 32'h24, 0);
        #1;
        chk("beq_nt_js", jump_select, 0);
        tick();
        chk("beq_nt_valid", x_valid, 1);
        chk("beq_nt_pc", x_pc, 32'h24);

        // JALR x1, 4(x5) held by busy for 3 cycles
        rf[5] = 32'h200;
        drive(1, JALR, 32'h30, 0);
        tick();
        base = m_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1, NOP, 32'h34, 1);
            #1;
            chk("stall_clk_en", e_clk_en, 0);
            chk("stall_js", jump_select, 0);
            chk("stall_x_pc", x_pc, 32'h30);
            tick();
        end
        drive(1, NOP, 32'h34, 0);
        #1;
        chk("jalr_js", jump_select, 1);
        chk("jalr_target", e_pc_next, 32'h204);
        chk("jalr_cnt_hold", x_retire_cnt, base);
        tick();
        chk("jalr_cnt_inc", x_retire_cnt, base + 1);
        chk("jalr_bubble", x_valid, 0);

        // JALR to 0x102
        rf[5] = 32'hFE;
        drive(1, JALR, 32'h40, 0);
        tick();
        drive(1, NOP, 32'h44, 0);
        #1;
`ifdef IEXEC_MISALIGN_TRAP_EN
        chk("mis_target", e_pc_next, 32'h100);
        chk("mis_trap", x_trap, 1);
`else
        chk("mis_target", e_pc_next, 32'h102);
        chk("mis_trap", x_trap, 0);
`endif
        chk("mis_js", jump_select, 1);
        tick();
        chk("mis_trap_gone", x_trap, 0);

        // asynchronous reset in the middle of a stall
        rf[5] = 32'h200;
        drive(1, JALR, 32'h50, 0);
        tick();
        drive(1, NOP, 32'h54, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("stallrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 16 == 0) begin
                for (int i = 0; i < 8; i++)
                    rf[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            end
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom(), $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
